// File: rtl/my_divider.sv
// Programmable integer clock divider: clk_out period is exactly div clk_in cycles.
// A new ratio is latched only at the period boundary, so phases are never cut short.
module my_divider #(
    parameter int WIDTH   = 32,
    parameter int MIN_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] div,
    output logic             clk_out
);

    localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < MIN_DIV_W) ? MIN_DIV_W : d;
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_eff;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_next;
    logic             term_cnt;

    assign n_eff    = clamp_div(div);
    assign half     = n_act >> 1;
    assign cnt_next = cnt + 1'b1;
    assign term_cnt = (cnt == n_act - 1'b1);

    // cnt stays below n_act, so cnt_next never wraps even at the maximum ratio
    always_ff @(posedge clk_in) begin
        if (reset) begin
            n_act   <= n_eff;
            cnt     <= n_eff - 1'b1;
            clk_out <= 1'b0;
        end else if (term_cnt) begin
            n_act   <= n_eff;
            cnt     <= '0;
            clk_out <= 1'b1;
        end else begin
            cnt     <= cnt_next;
            clk_out <= (cnt_next < half);
        end
    end

endmodule

// File: tb/tb_my_divider.sv
// Directed checks of my_divider: reset, ratio changes at period boundaries, odd ratios,
// clamping, mid-period reset, maximum ratio, then random ratio changes against a phase model.
module tb_my_divider;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [31:0] div;
    logic        clk_out;

    int vectors     = 0;
    int miscompares = 0;

    my_divider #(.WIDTH(32), .MIN_DIV(2)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .div    (div),
        .clk_out(clk_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input logic exp, input string tag);
        @(posedge clk_in);
        #1;
        vectors++;
        assert (clk_out === exp) else begin
            miscompares++;
            $error("FAIL %s: clk_out=%b expected %b", tag, clk_out, exp);
        end
    endtask

    task automatic period(input int high, input int low, input string tag);
        repeat (high) step(1'b1, tag);
        repeat (low) step(1'b0, tag);
    endtask

    function automatic int unsigned tb_clamp(input int unsigned d);
        if (d < 2) return 2;
        return d;
    endfunction

    int unsigned m_n;
    int unsigned m_pos;
    int unsigned last_rise;

    initial begin
        reset = 1'b1;
        div   = 32'd4;

        // Reset holds clk_out low; first edge after release starts a period
        step(1'b0, "reset_0");
        step(1'b0, "reset_1");
        reset = 1'b0;
        period(2, 2, "div4_first");
        period(2, 2, "div4_b");

        // Ratio change mid-period: current period finishes with the old ratio
        step(1'b1, "div4_to8_tc");
        div = 32'd8;
        step(1'b1, "div4_to8_hold_h");
        step(1'b0, "div4_to8_hold_l");
        step(1'b0, "div4_to8_hold_l");
        period(4, 4, "div8");
        step(1'b1, "div8_to16_tc");
        div = 32'd16;
        repeat (3) step(1'b1, "div8_to16_hold_h");
        repeat (4) step(1'b0, "div8_to16_hold_l");
        period(8, 8, "div16");
        step(1'b1, "div16_to32_tc");
        div = 32'd32;
        repeat (7) step(1'b1, "div16_to32_hold_h");
        repeat (8) step(1'b0, "div16_to32_hold_l");
        period(16, 16, "div32");

        // Odd ratios: high phase one cycle shorter
        step(1'b1, "div32_to3_tc");
        div = 32'd3;
        repeat (15) step(1'b1, "div32_to3_hold_h");
        repeat (16) step(1'b0, "div32_to3_hold_l");
        repeat (10) period(1, 2, "div3");
        step(1'b1, "div3_to5_tc");
        div = 32'd5;
        repeat (2) step(1'b0, "div3_to5_hold_l");
        repeat (10) period(2, 3, "div5");

        // div 0 and 1 clamp to 2
        step(1'b1, "div5_to0_tc");
        div = 32'd0;
        step(1'b1, "div5_to0_hold_h");
        repeat (3) step(1'b0, "div5_to0_hold_l");
        repeat (6) period(1, 1, "div0");
        div = 32'd1;
        repeat (6) period(1, 1, "div1");
        div = 32'd2;
        repeat (6) period(1, 1, "div2");

        // Reset during the high phase of a div=8 period
        step(1'b1, "div2_to8_tc");
        div = 32'd8;
        step(1'b0, "div2_to8_hold_l");
        step(1'b1, "div8_pre_rst_h");
        step(1'b1, "div8_pre_rst_h");
        reset = 1'b1;
        step(1'b0, "mid_reset");
        reset = 1'b0;
        period(4, 4, "div8_after_rst");
        period(4, 4, "div8_after_rst");

        // Maximum ratio is legal; just check the start of its long high phase
        div   = 32'hFFFF_FFFF;
        reset = 1'b1;
        step(1'b0, "max_reset");
        reset = 1'b0;
        repeat (6) step(1'b1, "max_high");

        // Random ratio changes every cycle, checked against a position-in-period model
        div   = 32'd5;
        reset = 1'b1;
        step(1'b0, "rand_reset");
        m_n   = 5;
        m_pos = 4;
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            div = 32'($urandom_range(0, 12));
            if (m_pos + 1 == m_n) begin
                m_n   = tb_clamp(div);
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            step(m_pos < (m_n / 2), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
